// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul block and its operand loaders.
package matmul_pkg;

    // Element width that matmul and the loaders agree on by default.
    localparam int MM_DATA_WIDTH = 16;

    // Loader states: FILL accepts elements, FULL presents the finished matrix.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index ranging over 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column position counter for row-major matrix filling. Tracks the
// element count alongside row/col and flags the last index of the matrix.
module rc_counter
    import matmul_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int RW  = idx_width(ROWS),
    localparam int CW  = idx_width(COLS),
    localparam int NW  = cnt_width(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          zero,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [NW-1:0] count,
    output logic          last_idx
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [NW-1:0] count_q, count_d;

    // Next position: synchronous zero wins, otherwise step col with row carry.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        count_d = count_q;
        if (zero) begin
            row_d   = '0;
            col_d   = '0;
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign count    = count_q;
    assign last_idx = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/mat_stream_loader.sv
// Operand loader for matmul: collects a row-major element stream into a
// ROWS x COLS register array and hands the whole matrix over with valid/ready.
module mat_stream_loader
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    localparam int NW        = cnt_width(ROWS * COLS)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clear,
    input  logic                                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]                  in_data,
    input  logic                                          in_last,
    output logic                                          in_ready,
    output logic signed [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_out,
    output logic                                          mat_valid,
    input  logic                                          mat_ready,
    output logic [NW-1:0]                                 fill_count,
    output logic                                          err
);

    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);

    loader_state_t state_q, state_d;
    logic          err_q, err_d;
    logic signed [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_q, mat_d;

    logic          accept;
    logic          wr_en;
    logic          cnt_zero;
    logic          cnt_inc;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [NW-1:0] count;
    logic          last_idx;

    rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rc_counter (
        .clk      (clk),
        .rst_n    (reset),
        .zero     (cnt_zero),
        .inc      (cnt_inc),
        .row      (row),
        .col      (col),
        .count    (count),
        .last_idx (last_idx)
    );

    // Ready depends only on registered state; held low while reset is asserted.
    assign in_ready = (state_q == FILL) && reset;
    assign accept   = in_valid && in_ready;

    // Control: clear overrides everything, then framing checks on accept,
    // then the FULL -> FILL return on mat_ready.
    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        cnt_zero = 1'b0;
        cnt_inc  = 1'b0;
        if (clear) begin
            state_d  = FILL;
            cnt_zero = 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (last_idx && in_last) begin
                            state_d  = FULL;
                            cnt_zero = 1'b1;
                        end else if (last_idx || in_last) begin
                            err_d    = 1'b1;
                            cnt_zero = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (mat_ready) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d  = FILL;
                    cnt_zero = 1'b1;
                end
            endcase
        end
    end

    // Element write into the held matrix; entries are never cleared by framing.
    always_comb begin
        mat_d = mat_q;
        if (wr_en) begin
            mat_d[row][col] = in_data;
        end
    end

    // State, error pulse and matrix storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            err_q   <= 1'b0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            mat_q   <= mat_d;
        end
    end

    assign mat_valid  = (state_q == FULL);
    assign mat_out    = mat_q;
    assign fill_count = count;
    assign err        = err_q;

endmodule

// File: tb/tb_mat_stream_loader.sv
// Bench for mat_stream_loader at ROWS=2, COLS=3 with a matrix scoreboard.
module tb_mat_stream_loader;

    localparam int DW = 16;
    localparam int R  = 2;
    localparam int C  = 3;
    localparam int N  = R * C;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             clear;
    logic                             in_valid;
    logic signed [DW-1:0]             in_data;
    logic                             in_last;
    logic                             in_ready;
    logic signed [R-1:0][C-1:0][DW-1:0] mat_out;
    logic                             mat_valid;
    logic                             mat_ready;
    logic [2:0]                       fill_count;
    logic                             err;

    int n_checks = 0;
    int n_errors = 0;

    logic [N*DW-1:0] sb[$];
    logic [DW-1:0]   fr[N];
    logic            mv_prev = 1'b0;

    mat_stream_loader #(
        .DATA_WIDTH (DW),
        .ROWS       (R),
        .COLS       (C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mat_out    (mat_out),
        .mat_valid  (mat_valid),
        .mat_ready  (mat_ready),
        .fill_count (fill_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare the matrix whenever mat_valid rises.
    always @(negedge clk) begin
        if (mat_valid && !mv_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_mat_valid", 1, 0);
            end else begin
                logic [N*DW-1:0] e;
                e = sb.pop_front();
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        chk($sformatf("mat[%0d][%0d]", r, c), mat_out[r][c], e[(r*C+c)*DW +: DW]);
            end
        end
        mv_prev <= mat_valid;
    end

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drive one element and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send fr[0..n-1]; in_last on index last_at; push expected matrix if push.
    task automatic run_frame(input int n, input int last_at, input bit gaps, input bit push);
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = fr[i];
        if (push) sb.push_back(p);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            chk($sformatf("fill_count_before_%0d", i), fill_count, i);
            send(fr[i], i == last_at);
        end
    endtask

    task automatic release_mat();
        mat_ready = 1'b1;
        @(posedge clk); #1;
        mat_ready = 1'b0;
        chk("release_mat_valid", mat_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    task automatic set_fr(input int a, input int b, input int c, input int d, input int e, input int f);
        fr[0] = DW'(a); fr[1] = DW'(b); fr[2] = DW'(c);
        fr[3] = DW'(d); fr[4] = DW'(e); fr[5] = DW'(f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] held;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; mat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mat_valid", mat_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_fill_count", fill_count, 0);
        chk("rst_mat_out", mat_out, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Scenario 1: back-to-back frame.
        set_fr(1, 2, 3, 4, 5, 6);
        run_frame(N, N - 1, 1'b0, 1'b1);
        chk("s1_mat_valid", mat_valid, 1);
        chk("s1_in_ready", in_ready, 0);
        chk("s1_fill_count", fill_count, 0);

        // Scenario 2: hold in FULL while in_valid toggles.
        held = mat_out;
        in_data = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            @(posedge clk); #1;
            chk("s2_mat_valid", mat_valid, 1);
            chk("s2_in_ready", in_ready, 0);
            chk("s2_mat_hold", mat_out, held);
        end
        in_valid = 1'b0;
        release_mat();

        // Scenario 3: extreme values with gaps.
        set_fr(-32768, 32767, -1, 0, 7, -7);
        run_frame(N, N - 1, 1'b1, 1'b1);
        chk("s3_mat_valid", mat_valid, 1);
        chk("s3_fill_count_full", fill_count, 0);
        release_mat();

        // Scenario 4a: early last on element 4.
        set_fr(11, 12, 13, 14, 15, 16);
        run_frame(4, 3, 1'b0, 1'b0);
        chk("s4a_err", err, 1);
        chk("s4a_fill_count", fill_count, 0);
        chk("s4a_in_ready", in_ready, 1);
        chk("s4a_mat_valid", mat_valid, 0);
        idle();
        chk("s4a_err_one_cycle", err, 0);
        // Clean frame after error.
        set_fr(21, 22, 23, 24, 25, 26);
        run_frame(N, N - 1, 1'b0, 1'b1);
        chk("s4b_mat_valid", mat_valid, 1);
        chk("s4b_err", err, 0);
        release_mat();
        // Scenario 4c: missing last on element 6.
        set_fr(31, 32, 33, 34, 35, 36);
        run_frame(N, -1, 1'b0, 1'b0);
        chk("s4c_err", err, 1);
        chk("s4c_fill_count", fill_count, 0);
        chk("s4c_mat_valid", mat_valid, 0);
        idle();
        chk("s4c_err_one_cycle", err, 0);

        // Scenario 5: clear mid-frame, clear in FULL, clear with final accept.
        set_fr(41, 42, 43, 44, 45, 46);
        run_frame(3, -1, 1'b0, 1'b0);
        chk("s5_fill_count_3", fill_count, 3);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("s5_clear_fill_count", fill_count, 0);
        chk("s5_clear_err", err, 0);
        run_frame(N, N - 1, 1'b0, 1'b1);
        chk("s5_full", mat_valid, 1);
        held = mat_out;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("s5_clear_full_valid", mat_valid, 0);
        chk("s5_clear_full_mat", mat_out, held);
        set_fr(51, 52, 53, 54, 55, 56);
        run_frame(N - 1, -1, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = fr[N-1]; in_last = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
        chk("s5_clear_final_valid", mat_valid, 0);
        chk("s5_clear_final_fc", fill_count, 0);
        chk("s5_clear_final_err", err, 0);
        chk("s5_clear_final_elem", mat_out[1][2], held[5*DW +: DW]);

        // Scenario 6: asynchronous reset mid-frame.
        set_fr(61, 62, 63, 64, 65, 66);
        run_frame(3, -1, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = fr[3];
        #3;
        reset = 1'b0;
        #1;
        chk("s6_in_ready", in_ready, 0);
        chk("s6_mat_valid", mat_valid, 0);
        chk("s6_err", err, 0);
        chk("s6_fill_count", fill_count, 0);
        chk("s6_mat_out", mat_out, 0);
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        set_fr(71, -72, 73, -74, 75, -76);
        run_frame(N, N - 1, 1'b0, 1'b1);
        chk("s6_reload_valid", mat_valid, 1);
        release_mat();

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
